// File: rtl/fpu_add_sched.sv
// Round-robin scheduler that shares one integer add/subtract datapath among NUM_REQ requesters.
// The result is held in a single-entry buffer and returned on one shared, backpressured channel.
module fpu_add_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IDW     = 2,
    parameter int unsigned CNTW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_add_sub,
    input  logic [NUM_REQ*WIDTH-1:0] req_opa,
    input  logic [NUM_REQ*WIDTH-1:0] req_opb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [CNTW-1:0]          ops_done
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             can_accept;
    logic             accept;
    logic             complete;
    logic             sel_add;
    logic [WIDTH-1:0] op_a, op_b, sum_res;

    // Round-robin search starting just above the last accepted requester.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx  = (32'(last_grant_q) + k) % NUM_REQ;
            cand = IDW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign can_accept = (state_q == StEmpty) | rsp_ready;
    assign complete   = (state_q == StFull) & rsp_ready;

    // rst_n gates the handshake so nothing is offered while reset is asserted.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n & grant_found & can_accept & (grant_idx == IDW'(i));
        end
    end

    assign accept = |(req_valid & req_ready);

    // Operand mux feeding the shared datapath.
    always_comb begin
        op_a    = '0;
        op_b    = '0;
        sel_add = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                op_a    = req_opa[i*WIDTH +: WIDTH];
                op_b    = req_opb[i*WIDTH +: WIDTH];
                sel_add = req_add_sub[i];
            end
        end
    end

    // Carry and borrow fall off the top; result is modulo 2^WIDTH.
    assign sum_res = sel_add ? (op_a + op_b) : (op_a - op_b);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        if (complete) begin
            cnt_d   = cnt_q + CNTW'(1);
            state_d = StEmpty;
        end
        if (accept) begin
            state_d      = StFull;
            last_grant_d = grant_idx;
            id_d         = grant_idx;
            sum_d        = sum_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            last_grant_q <= IDW'(NUM_REQ - 1);
            id_q         <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign ops_done  = cnt_q;

endmodule

// File: tb/tb_fpu_add_sched.sv
// Randomized scoreboard bench for fpu_add_sched with a behavioural reference model.
module tb_fpu_add_sched;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_add_sub = '0;
    logic [NR*W-1:0]   req_opa = '0;
    logic [NR*W-1:0]   req_opb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [CW-1:0]     ops_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  sum;
    } exp_t;

    exp_t sb_q[$];
    int   m_last = NR - 1;
    bit   m_full = 1'b0;
    int   m_cnt  = 0;

    always #5 clk = ~clk;

    fpu_add_sched #(
        .NUM_REQ(NR),
        .WIDTH  (W),
        .IDW    (IW),
        .CNTW   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_add_sub(req_add_sub),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .ops_done   (ops_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates each cycle's handshake at the falling edge.
    always @(negedge clk) begin
        logic [NR-1:0] exp_ready;
        logic [W-1:0]  a, b;
        exp_t          e;
        int            win;
        bit            can;
        exp_ready = '0;
        a = '0;
        b = '0;
        e = '0;
        win = -1;
        can = 1'b0;
        if (!rst_n) begin
            chk("reset_req_ready", 64'(req_ready), 64'(0));
            chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
            m_last = NR - 1;
            m_full = 1'b0;
            m_cnt  = 0;
            sb_q.delete();
        end else begin
            can = !m_full || rsp_ready;
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_last + k) % NR;
                if (win < 0 && req_valid[i]) win = i;
            end
            if (win >= 0 && can) exp_ready[win] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
            chk("ops_done", 64'(ops_done), 64'(m_cnt));
            if (m_full && rsp_ready) m_cnt = (m_cnt + 1) % (1 << CW);
            if (exp_ready != '0) begin
                a = req_opa[win*W +: W];
                b = req_opb[win*W +: W];
                e.id  = IW'(win);
                e.sum = req_add_sub[win] ? a + b : a - b;
                sb_q.push_back(e);
                m_last = win;
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: any presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t f;
        f = '0;
        if (rst_n && rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d sum %0h, required no response",
                         rsp_id, rsp_sum);
            end else begin
                f = sb_q[0];
                chk("rsp_id", 64'(rsp_id), 64'(f.id));
                chk("rsp_sum", 64'(rsp_sum), 64'(f.sum));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic as, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_valid[i]       = 1'b1;
        req_add_sub[i]     = as;
        req_opa[i*W +: W]  = a;
        req_opb[i*W +: W]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] rr_exp;
        logic [W-1:0]  a1, b1;
        rr_exp = '0;

        // Reset and idle
        step(3);
        rst_n = 1'b1;
        step(10);

        // Single op on requester 2
        set_req(2, 1'b1, 32'h5, 32'h3);
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        step(1);
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 64'(rsp_valid), 64'(1));
        chk("single_id", 64'(rsp_id), 64'(2));
        chk("single_sum", 64'(rsp_sum), 64'(32'h8));
        step(1);
        chk("single_ops_done", 64'(ops_done), 64'(1));

        // Wrap-around arithmetic
        set_req(0, 1'b0, 32'h1, 32'h2);
        step(1);
        req_valid = '0;
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sub_wrap", 64'(rsp_sum), 64'(32'hFFFF_FFFF));
        step(1);
        req_valid = '0;
        @(negedge clk);
        chk("add_wrap", 64'(rsp_sum), 64'(32'hFFFF_FFFE));
        step(2);

        // Round-robin with all requesters valid, starting fresh from reset
        do_reset();
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NR; i++) set_req(i, 1'($urandom), $urandom, $urandom);
            @(negedge clk);
            rr_exp = '0;
            rr_exp[c % NR] = 1'b1;
            chk("rr_grant", 64'(req_ready), 64'(rr_exp));
            if (c > 0) chk("rr_rsp_id", 64'(rsp_id), 64'((c - 1) % NR));
            step(1);
        end
        req_valid = '0;
        step(2);

        // Backpressure: last grant was 3, so requester 1 wins first
        a1 = $urandom;
        b1 = $urandom;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, a1, b1);
        set_req(3, 1'b0, $urandom, $urandom);
        @(negedge clk);
        chk("bp_first_grant", 64'(req_ready), 64'(4'b0010));
        step(1);
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(req_ready), 64'(0));
            chk("bp_hold_id", 64'(rsp_id), 64'(1));
            chk("bp_hold_sum", 64'(rsp_sum), 64'(a1 + b1));
            step(1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'(req_ready), 64'(4'b1000));
        chk("bp_release_valid", 64'(rsp_valid), 64'(1));
        step(1);
        @(negedge clk);
        chk("bp_next_id", 64'(rsp_id), 64'(3));
        req_valid = '0;
        step(2);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = ($urandom % 3) != 0;
                req_add_sub[i] = 1'($urandom);
                req_opa[i*W +: W] = $urandom;
                req_opb[i*W +: W] = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            rsp_ready = ($urandom % 4) != 0;
            step(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step(3);

        // Reset while FULL drops the buffered result at once
        rsp_ready = 1'b0;
        set_req(0, 1'b1, $urandom, $urandom);
        step(1);
        req_valid = '0;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop_valid", 64'(rsp_valid), 64'(0));
        chk("async_drop_ready", 64'(req_ready), 64'(0));
        step(1);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // 17 completions wrap a 4-bit counter to 1
        for (int c = 0; c < 17; c++) begin
            set_req(2, 1'($urandom), $urandom, $urandom);
            step(1);
        end
        req_valid = '0;
        step(1);
        @(negedge clk);
        chk("cnt_wrap", 64'(ops_done), 64'(1));
        step(2);

        chk("sb_drained", 64'(sb_q.size()), 64'(m_full ? 1 : 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Round-robin scheduler that shares the single integer add/subtract datapath of the FPU `addition` unit among NUM_REQ requesters. Each requester presents operands and an add/sub select over a valid/ready handshake. The scheduler grants one requester per cycle and computes the sum through the shared datapath. It returns the registered result, tagged with the requester index, on one shared response channel with backpressure.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- WIDTH, default 32: operand/result width (matches the FPU `BIT_SIZE`+1).
- IDW, default 2: width of the requester index, equal to clog2(NUM_REQ).
- CNTW, default 16: width of the completed-operation counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_add_sub  in  NUM_REQ  per-requester op select: 1 = add, 0 = subtract.
- req_opa  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_opb  in  NUM_REQ*WIDTH  operand B, packed the same way.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  result.
- ops_done  out  CNTW  count of completed responses (rsp_valid & rsp_ready); wraps modulo 2^CNTW.

## Operation
- Result buffer FSM, two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- can_accept = (state == EMPTY) | rsp_ready.
- Arbitration: round-robin over the requesters with req_valid set.
  - Search starts at (last_grant + 1) mod NUM_REQ and proceeds upward with wrap; the first valid index wins (grant_idx).
  - req_ready[grant_idx] = can_accept; every other req_ready bit is 0. With no valid requesters, all req_ready bits are 0.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept occurs when req_valid[g] & req_ready[g]. On accept:
  - sum = add_sub ? opa + opb : opa − opb, computed modulo 2^WIDTH; carry and borrow are discarded.
  - rsp_sum ← sum, rsp_id ← g, state ← FULL, last_grant ← g.
- last_grant updates only on accept. Valid requesters that cannot be accepted do not advance the pointer.
- Response completes when rsp_valid & rsp_ready.
  - Completion with no new accept in the same cycle: state ← EMPTY.
  - Completion and accept in the same cycle: state stays FULL and the new result replaces the old one (back-to-back).
- While FULL and rsp_ready = 0: rsp_sum and rsp_id hold stable, and no request is accepted.
- ops_done increments by 1 on every completed response and wraps from 2^CNTW−1 to 0.
- Request fields (add_sub, opa, opb) are sampled only in the accept cycle.

## Timing
- Latency: a request accepted at edge N produces rsp_valid high after edge N, in cycle N+1.
- Throughput: one operation per cycle while rsp_ready stays high.
- Reset values (rst_n low, asynchronous): state = EMPTY, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, ops_done = 0, last_grant = NUM_REQ−1 (requester 0 has first priority after reset).
- During reset, req_ready = 0.
- Reset asserted mid-operation discards any buffered result with no response emitted. Deassertion is synchronized externally; the first accept can occur on the first edge with rst_n high.
- Fairness: a requester that holds req_valid waits at most NUM_REQ−1 accepts by other requesters before it is granted.

## Test plan
- Reset and idle: release reset with all req_valid = 0.
  - Required: rsp_valid = 0, ops_done = 0, req_ready = 0 for 10 cycles.
- Single op: requester 2 presents opa = 0x0000_0005, opb = 0x0000_0003, add_sub = 1, with rsp_ready = 1.
  - Required: req_ready[2] high in the same cycle; next cycle rsp_valid = 1, rsp_id = 2, rsp_sum = 0x0000_0008; ops_done = 1 afterwards.
- Subtract wrap: opa = 0x0000_0001, opb = 0x0000_0002, add_sub = 0.
  - Required: rsp_sum = 0xFFFF_FFFF.
  - Also: opa = opb = 0xFFFF_FFFF, add_sub = 1 → rsp_sum = 0xFFFF_FFFE.
- Round-robin: all 4 requesters hold valid continuously with rsp_ready = 1.
  - Required: grant order 0,1,2,3,0,1,… one per cycle; rsp_id follows the same order one cycle later.
- Backpressure: hold rsp_ready = 0 for 5 cycles while requesters 1 and 3 are valid.
  - Required: the first accepted result holds stable; req_ready = 0 while FULL.
  - On release: completion and the next accept happen in the same cycle, with no bubble.
- Reset mid-op and counter wrap:
  - Assert rst_n low while FULL → rsp_valid drops immediately.
  - With CNTW = 4, complete 17 responses → ops_done = 1.
